// File: rtl/fa16_addsub_c_if.sv
// -----------------------------------------------------------------------------
// fa16_addsub_c_if
// Operand/result bundle for the 16-bit ALU adder/subtractor.
//
//   A, B    operands (WIDTH bits)
//   PSW_C   current PSW carry flag
//   ALUop   0 = add, 1 = subtract
//   Flag    0 = implicit carry-in, 1 = use PSW_C as carry-in
//   Sum     registered result (WIDTH bits)
//   Cout    registered carry-out of bit WIDTH-1
//
// master : the side that issues operands (ALU control / testbench)
// slave  : the adder itself
// -----------------------------------------------------------------------------
interface fa16_addsub_c_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             PSW_C;
   logic             ALUop;
   logic             Flag;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (
      output A, B, PSW_C, ALUop, Flag,
      input  Sum, Cout
   );

   modport slave (
      input  A, B, PSW_C, ALUop, Flag,
      output Sum, Cout
   );
endinterface : fa16_addsub_c_if

// File: rtl/fa16_addsub_c.sv
// -----------------------------------------------------------------------------
// fa16_addsub_c
// Registered WIDTH-bit adder/subtractor with optional carry chaining from the
// PSW carry flag (ADD / SUB / ADC / SBC). One-cycle latency, one result per
// cycle, no enable.
//
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset; clears Sum and Cout immediately
//   bus    fa16_addsub_c_if.slave: operands A/B, PSW_C, ALUop, Flag in;
//          Sum/Cout out
//
// Cout is the raw adder carry. On subtraction Cout=1 means "no borrow".
// -----------------------------------------------------------------------------
module fa16_addsub_c #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fa16_addsub_c_if.slave     bus
);

   logic [WIDTH-1:0] b_x;      // conditioned operand B
   logic             cin;      // selected carry-in
   logic [WIDTH:0]   carry;    // carry[i] enters bit i; carry[WIDTH] is carry-out
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   // Subtraction is A + ~B + 1; the "+1" is the carry-in unless the PSW
   // carry is chained in for ADC/SBC.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      b_x   = bus.ALUop ? ~bus.B : bus.B;
      cin   = bus.Flag ? bus.PSW_C : bus.ALUop;
      carry = '0;
      sum_d = '0;

      carry[0] = cin;
      // Ripple chain of full-adder cells, LSB first.
      for (int i = 0; i < WIDTH; i++) begin
         sum_d[i]   = bus.A[i] ^ b_x[i] ^ carry[i];
         carry[i+1] = (bus.A[i] & b_x[i]) | (carry[i] & (bus.A[i] ^ b_x[i]));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= carry[WIDTH];
      end
   end

   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;

endmodule : fa16_addsub_c

// File: tb/tb_fa16_addsub_c.sv
// -----------------------------------------------------------------------------
// tb_fa16_addsub_c
// Self-checking bench for fa16_addsub_c. Stimulus is driven on the falling
// edge and the expected result is pushed into a scoreboard queue at the same
// moment; an independent monitor pops one entry per rising edge (sampled 1 ns
// after the edge) and compares Sum and Cout. Directed cases carry hand-derived
// expected constants; random cases use a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fa16_addsub_c;

   localparam int WIDTH = 16;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      string            name;
   } exp_t;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             psw_c;
      logic             op;
      logic             flag;
      logic [WIDTH-1:0] sum;
      logic             cout;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fa16_addsub_c_if #(.WIDTH(WIDTH)) bus ();

   fa16_addsub_c #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: the (WIDTH+1)-bit arithmetic sum, done with plain integers.
   function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic psw_c, input logic op, input logic flag,
                                      input string name);
      exp_t           e;
      longint unsigned bx, cin, total, modulus;
      modulus = 64'd1 << WIDTH;
      bx      = op ? (modulus - 1 - 64'(b)) : 64'(b);
      cin     = flag ? 64'(psw_c) : 64'(op);
      total   = 64'(a) + bx + cin;
      e.sum   = WIDTH'(total % modulus);
      e.cout  = (total >= modulus);
      e.name  = name;
      return e;
   endfunction

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic psw_c, input logic op, input logic flag);
      bus.A     = a;
      bus.B     = b;
      bus.PSW_C = psw_c;
      bus.ALUop = op;
      bus.Flag  = flag;
   endtask

   task automatic apply_vec(input vec_t v);
      exp_t e;
      @(negedge clk);
      drive(v.a, v.b, v.psw_c, v.op, v.flag);
      e.sum  = v.sum;
      e.cout = v.cout;
      e.name = v.name;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry is retired per rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, "_sum"},  32'(bus.Sum),  32'(e.sum));
            check({e.name, "_cout"}, 32'(bus.Cout), 32'(e.cout));
         end
      end
   end

   // Directed cases: name, A, B, PSW_C, ALUop, Flag, expected Sum, expected Cout.
   vec_t dir_vecs[] = '{
      '{"add_wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1},
      '{"add_ign_pswc",  16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0},
      '{"sub_5_3",       16'h0005, 16'h0003, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1},
      '{"sub_3_5",       16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0},
      '{"sub_8000",      16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1},
      '{"sub_0_1",       16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'hFFFF, 1'b0},
      '{"sub_a_a",       16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1},
      '{"adc_7fff",      16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b0},
      '{"adc_ffff",      16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1},
      '{"adc_c0",        16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0},
      '{"adc_c1",        16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0},
      '{"sbc_5_3_c0",    16'h0005, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b1},
      '{"sbc_0_0_c0",    16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0},
      '{"sbc_5_3_c1",    16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b1},
      '{"add_5a5a",      16'h5A5A, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0}
   };

   function automatic logic [WIDTH-1:0] rand_operand();
      logic [WIDTH-1:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
      if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
      return WIDTH'($urandom);
   endfunction

   initial begin
      exp_t e;
      drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Reset state before any clock edge.
      #2;
      check("reset_init_sum",  32'(bus.Sum),  32'h0);
      check("reset_init_cout", 32'(bus.Cout), 32'h0);

      // Load a known value (1234) so the async reset has something to clear.
      @(negedge clk);
      rst_n = 1'b1;
      e = '{sum: 16'h1234, cout: 1'b0, name: "pre_reset"};
      drive(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(e);

      // Assert reset mid-cycle, away from any edge; outputs must clear at once.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("reset_async_sum",  32'(bus.Sum),  32'h0);
      check("reset_async_cout", 32'(bus.Cout), 32'h0);

      // Hold for two edges with a nonzero operand pattern applied.
      drive(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold_sum",  32'(bus.Sum),  32'h0);
      check("reset_hold_cout", 32'(bus.Cout), 32'h0);

      // Release; the very next edge captures 1234+4321.
      @(negedge clk);
      rst_n = 1'b1;
      drive(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
      e = '{sum: 16'h5555, cout: 1'b0, name: "add_first"};
      exp_q.push_back(e);

      foreach (dir_vecs[i]) apply_vec(dir_vecs[i]);

      // Back-to-back random vectors, new inputs every cycle.
      for (int n = 0; n < 1000; n++) begin
         logic [WIDTH-1:0] a, b;
         logic             c, op, fl;
         a  = rand_operand();
         b  = rand_operand();
         c  = 1'($urandom_range(0, 1));
         op = 1'($urandom_range(0, 1));
         fl = 1'($urandom_range(0, 1));
         @(negedge clk);
         drive(a, b, c, op, fl);
         exp_q.push_back(ref_model(a, b, c, op, fl, "rand"));
      end

      // Let the last result retire, then confirm nothing was left unchecked.
      @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_fa16_addsub_c

// File: doc/fa16_addsub_c.md
Name: fa16_addsub_c

Overview:
- 16-bit adder/subtractor with carry-chain option for the multicycle RISC ALU datapath.
- Computes A+B or A−B (two's complement). Carry-in is either implicit or taken from the PSW carry bit (ADC/SBC forms).
- Result and carry-out are registered: one-cycle latency into the ALU output stage.

Parameters:
- WIDTH, 16, operand/result width. Must stay 16 for ISA use; logic must be generic in WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  16  operand A (unsigned/two's complement)
- B  input  16  operand B
- PSW_C  input  1  current PSW carry flag
- ALUop  input  1  0 = add, 1 = subtract
- Flag  input  1  0 = ignore PSW_C, 1 = use PSW_C as carry-in
- Sum  output  16  registered result
- Cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Operand conditioning: Bx = B when ALUop=0, Bx = ~B (bitwise) when ALUop=1.
- Carry-in selection:
  - Flag=0: cin = ALUop (ADD: 0; SUB: 1, true two's complement).
  - Flag=1: cin = PSW_C (ADC: A+B+C; SBC: A+~B+C).
- Arithmetic: {c, s} = A + Bx + cin over WIDTH+1 bits. No saturation; the result wraps modulo 2^16.
- Implementation: ripple-carry chain of 1-bit full-adder cells, per-bit sum = a^b^ci and carry = ab | ci(a^b). A carry-lookahead realisation is allowed if results are bit-identical.
- Cout is the raw adder carry-out. For subtraction, Cout=1 means no borrow (A>=B unsigned when cin=1); it is not inverted.
- Registers: on the rising edge of clk, Sum<=s and Cout<=c. Inputs are sampled every cycle with no enable. Outputs reflect inputs applied before the edge, i.e. latency 1 cycle, throughput 1/cycle.
- Reset: while rst_n=0, Sum=16'h0000 and Cout=0 immediately, regardless of clk.
- Reset deassertion: the first capture happens at the first rising edge with rst_n=1.
- Reset mid-operation: any in-flight result is discarded; no recovery of the prior value.
- X/undriven inputs: no special handling; outputs follow the arithmetic.
- Boundaries:
  - FFFF+0001 → Sum 0000, Cout 1.
  - 0000−0001 → Sum FFFF, Cout 0 (borrow).
  - A−A → 0000, Cout 1.
  - Flag=1 with PSW_C=0 on SUB gives A−B−1.
  - Flag=1 with PSW_C=1 on ADD gives A+B+1.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with prior Sum=1234 → Sum=0000 and Cout=0 without a clock edge. Hold for 2 cycles, release; the next edge captures inputs.
- ADD: A=1234, B=4321, ALUop=0, Flag=0 → after 1 edge Sum=5555, Cout=0. Then A=FFFF, B=0001 → Sum=0000, Cout=1.
- SUB: ALUop=1, Flag=0:
  - A=0005, B=0003 → Sum=0002, Cout=1.
  - A=0003, B=0005 → Sum=FFFE, Cout=0.
  - A=8000, B=8000 → Sum=0000, Cout=1.
- ADC: ALUop=0, Flag=1:
  - A=7FFF, B=0000, PSW_C=1 → Sum=8000, Cout=0.
  - A=FFFF, B=FFFF, PSW_C=1 → Sum=FFFF, Cout=1.
  - PSW_C=0 with A=0001, B=0001 → Sum=0002.
- SBC: ALUop=1, Flag=1:
  - A=0005, B=0003, PSW_C=0 → Sum=0001, Cout=1.
  - A=0000, B=0000, PSW_C=0 → Sum=FFFF, Cout=0.
- Pipeline and random: change inputs every cycle for 1000 random vectors. Check that each registered output equals the reference (A + (ALUop?~B:B) + (Flag?PSW_C:ALUop)) of the previous cycle, on both Sum and Cout.
